echo_capture_fsm: RTL and testbench

- Receive-side counterpart of image_transmit_fsm.
- After each transmit burst ends, waits out transducer ring-down, then captures a fixed number of echo samples from the AFE/ADC into a local line buffer.
- Streams the line out byte-wise to the host link.
- Pulses mem_clear back to image_transmit_fsm to release the next transmit.

---
 rtl/echo_capture_fsm_pkg.sv | 31 +++
 rtl/echo_capture_fsm_if.sv | 20 ++
 rtl/echo_capture_fsm_line_buf.sv | 31 +++
 rtl/echo_capture_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_echo_capture_fsm.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/echo_capture_fsm_pkg.sv
// rtl/echo_capture_fsm_pkg.sv - image_pkg: state encodings and constants shared by the imaging transmit/receive FSMs
package image_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_BLANK   = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;
   localparam logic [2:0] ST_CLEAR   = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      ARMED   = ST_ARMED,
      BLANK   = ST_BLANK,
      CAPTURE = ST_CAPTURE,
      DRAIN   = ST_DRAIN,
      CLEAR   = ST_CLEAR
   } state_t;

   // first byte of every line when the line header is enabled
   localparam logic [7:0] HDR_SYNC = 8'hA5;

   localparam int DEF_NUM_SAMPLES  = 64;
   localparam int DEF_BLANK_CYCLES = 16;

   // bits needed to count 0..max_count-1, never less than one
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/echo_capture_fsm_if.sv
// rtl/echo_capture_fsm_if.sv - byte stream from the echo capture line buffer to the host link
interface echo_capture_fsm_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/echo_capture_fsm_line_buf.sv
// rtl/echo_capture_fsm_line_buf.sv - echo_line_buf: simple dual-port line RAM, registered read, no reset
module echo_line_buf #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // read port, data one cycle after the request
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/echo_capture_fsm.sv
// rtl/echo_capture_fsm.sv - echo capture and line readout FSM; define ECHO_HEADER_EN for the A5/line_idx line header
module echo_capture_fsm
   import image_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
   parameter int ADDR_W       = 6,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               transmit_in_progress,
   input  logic               afe_switch,
   input  logic [DATA_W-1:0]  adc_data,
   input  logic               adc_valid,
   echo_capture_fsm_if.master out_if,
   output logic               mem_clear,
   output logic               busy,
   output logic               overrun
);

`ifdef ECHO_HEADER_EN
   localparam int HDR_BYTES = 2;
`else
   localparam int HDR_BYTES = 0;
`endif
   localparam int LINE_LEN = NUM_SAMPLES + HDR_BYTES;
   // byte index spans the samples plus any header bytes
   localparam int IDX_W    = ADDR_W + 2;
   localparam int BLANK_W  = cnt_width(BLANK_CYCLES);

   localparam logic [ADDR_W-1:0]  WR_LAST    = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [IDX_W-1:0]   RD_LAST    = IDX_W'(LINE_LEN - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

   state_t             state_q, state_d;
   logic               tip_q, tip_qq;
   logic               rise, fall;
   logic [BLANK_W-1:0] blank_cnt;
   logic [ADDR_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]   rd_ptr;
   logic [IDX_W-1:0]   fetch_idx;
   logic [ADDR_W-1:0]  rd_addr;
   logic               wr_en, hs, fetch;
   logic               need_fetch, rd_pend;
   logic [DATA_W-1:0]  ram_rd_data, byte_val;
   logic [DATA_W-1:0]  out_data_q;
   logic               out_valid_q;
   logic               overrun_q;
`ifdef ECHO_HEADER_EN
   logic [IDX_W-1:0]   pend_idx;
   logic [7:0]         line_idx;
`endif

   assign rise = tip_q & ~tip_qq;
   assign fall = ~tip_q & tip_qq;

   // register transmit_in_progress, then one more stage for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tip_q  <= 1'b0;
         tip_qq <= 1'b0;
      end else begin
         tip_q  <= transmit_in_progress;
         tip_qq <= tip_q;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state plus the per-cycle write, handshake and fetch strobes
   always_comb begin
      state_d   = state_q;
      wr_en     = 1'b0;
      hs        = 1'b0;
      fetch     = 1'b0;
      fetch_idx = rd_ptr;
      case (state_q)
         IDLE: begin
            if (rise) state_d = ARMED;
         end
         ARMED: begin
            if (fall) state_d = (BLANK_CYCLES == 0) ? CAPTURE : BLANK;
         end
         BLANK: begin
            if (blank_cnt == BLANK_LAST) state_d = CAPTURE;
         end
         CAPTURE: begin
            wr_en = adc_valid & ~afe_switch;
            if (wr_en && wr_ptr == WR_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            hs = out_valid_q & out_if.out_ready;
            // prefetch the next byte during the handshake so only one bubble follows
            if (need_fetch) begin
               fetch = 1'b1;
            end else if (hs && rd_ptr != RD_LAST) begin
               fetch     = 1'b1;
               fetch_idx = rd_ptr + 1'b1;
            end
            if (hs && rd_ptr == RD_LAST) state_d = CLEAR;
         end
         CLEAR: begin
            // a rise landing here belongs to the next line, not an overrun
            state_d = rise ? ARMED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ring-down counter and capture write pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blank_cnt <= '0;
         wr_ptr    <= '0;
      end else begin
         if (state_q == ARMED) begin
            blank_cnt <= '0;
         end else if (state_q == BLANK) begin
            blank_cnt <= blank_cnt + 1'b1;
         end
         if (wr_en) begin
            wr_ptr <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + 1'b1;
         end
      end
   end

   // readout pipeline: fetch -> RAM data -> output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr      <= '0;
         need_fetch  <= 1'b0;
         rd_pend     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         need_fetch <= (state_q == CAPTURE && state_d == DRAIN) ? 1'b1 : (need_fetch & ~fetch);
         rd_pend    <= fetch;
         if (state_q == CLEAR) begin
            rd_ptr <= '0;
         end else if (hs) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (hs) begin
            out_valid_q <= 1'b0;
         end else if (rd_pend) begin
            out_valid_q <= 1'b1;
            out_data_q  <= byte_val;
         end
      end
   end

`ifdef ECHO_HEADER_EN
   // remember which line byte is in flight so header bytes bypass the RAM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_idx <= '0;
      end else if (fetch) begin
         pend_idx <= fetch_idx;
      end
   end

   // line counter, advanced on every completed line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_idx <= 8'd0;
      end else if (state_q == CLEAR) begin
         line_idx <= line_idx + 8'd1;
      end
   end

   // select header or sample byte
   always_comb begin
      byte_val = ram_rd_data;
      if (pend_idx == '0) begin
         byte_val = DATA_W'(HDR_SYNC);
      end else if (pend_idx == IDX_W'(1)) begin
         byte_val = DATA_W'(line_idx);
      end
   end
`else
   assign byte_val = ram_rd_data;
`endif

   // transmit restarting before the line was handed back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun_q <= 1'b0;
      end else if (rise && state_q != IDLE && state_q != CLEAR) begin
         overrun_q <= 1'b1;
      end
   end

   assign rd_addr = ADDR_W'(fetch_idx - IDX_W'(HDR_BYTES));

   echo_line_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (adc_data),
      .rd_en   (fetch),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign mem_clear        = (state_q == CLEAR);
   assign busy             = (state_q != IDLE);
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_echo_capture_fsm.sv
// tb/tb_echo_capture_fsm.sv - bench for echo_capture_fsm (also builds with ECHO_HEADER_EN)
module tb_echo_capture_fsm;

   localparam int DATA_W       = 8;
   localparam int NUM_SAMPLES  = 64;
   localparam int ADDR_W       = 6;
   localparam int BLANK_CYCLES = 16;
`ifdef ECHO_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif
   localparam int LINE_LEN = NUM_SAMPLES + HDR;
   // input cycle (counted from the fall) of the first capturable sample:
   // one cycle to register the fall, one to leave ARMED, then the blanking window
   localparam int CAP_OFF = BLANK_CYCLES + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              tip = 1'b0;
   logic              afe = 1'b0;
   logic              adc_valid = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic              mem_clear, busy, overrun;

   echo_capture_fsm_if #(.DATA_W(DATA_W)) out_if();

   echo_capture_fsm #(
      .DATA_W       (DATA_W),
      .NUM_SAMPLES  (NUM_SAMPLES),
      .ADDR_W       (ADDR_W),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .transmit_in_progress (tip),
      .afe_switch           (afe),
      .adc_data             (adc_data),
      .adc_valid            (adc_valid),
      .out_if               (out_if),
      .mem_clear            (mem_clear),
      .busy                 (busy),
      .overrun              (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs  = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   bit         last_q[$];
   int         model_line = 0;

   int         mc_count = 0, mc_cyc = 0, first_valid_cyc = -1, hs_in_line = 0;
   int         mon_line = 0, byte_in_line = 0, ovr_cyc = -1;
   logic [7:0] line_b0[8], line_b1[8], line_fd[8], line_last[8];
   bit         prev_hs = 0, prev_hs_last = 0, prev_stall = 0, prev_mc = 0;
   logic [7:0] prev_data = '0;
   logic [7:0] mon_eb;
   bit         mon_el;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // per-cycle compare of the DUT against the line model
   always @(negedge clk) begin
      if (!rst) begin
         prev_hs = 0; prev_hs_last = 0; prev_stall = 0; prev_mc = 0; byte_in_line = 0;
      end else begin
         check("mem_clear", mem_clear, prev_hs_last);
         if (prev_hs) check("bubble", out_if.out_valid, 0);
         if (prev_stall) begin
            check("hold_valid", out_if.out_valid, 1);
            check("hold_data", out_if.out_data, prev_data);
         end
         if (prev_mc) check("busy_after_clear", busy, 0);
         if (ovr_cyc < 0) check("overrun", overrun, 0);
         else if (cyc >= ovr_cyc + 2) check("overrun", overrun, 1);
         if (out_if.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         prev_hs = (out_if.out_valid === 1'b1) && (out_if.out_ready === 1'b1);
         prev_hs_last = 0;
         if (prev_hs) begin
            if (exp_q.size() == 0) begin
               vecs++; fails++;
               $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", out_if.out_data, cyc);
            end else begin
               mon_eb = exp_q.pop_front();
               mon_el = last_q.pop_front();
               check("out_data", out_if.out_data, mon_eb);
               prev_hs_last = mon_el;
            end
            if (byte_in_line == 0) line_b0[mon_line % 8] = out_if.out_data;
            if (byte_in_line == 1) line_b1[mon_line % 8] = out_if.out_data;
            if (byte_in_line == HDR) line_fd[mon_line % 8] = out_if.out_data;
            line_last[mon_line % 8] = out_if.out_data;
            byte_in_line++;
            hs_in_line++;
         end
         if (mem_clear === 1'b1) begin
            mc_count++; mc_cyc = cyc; mon_line++; byte_in_line = 0;
         end
         prev_stall = (out_if.out_valid === 1'b1) && (out_if.out_ready !== 1'b1);
         prev_data  = out_if.out_data;
         prev_mc    = (mem_clear === 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one transmit/capture/readout line; the model queues the bytes the line must carry
   task automatic run_line(input int drop_n, input int mode, input bit ovr,
                           input int base, input int step, output int fall_cyc);
      int captured, dropped, budget, start_mc, k, off;
      logic [7:0] d;
      hs_in_line = 0;
      first_valid_cyc = -1;
`ifdef ECHO_HEADER_EN
      exp_q.push_back(8'hA5);           last_q.push_back(0);
      exp_q.push_back(8'(model_line));  last_q.push_back(0);
`endif
      tip = 1'b1;
      repeat (3) tick();
      tip = 1'b0;
      fall_cyc = cyc;
      off = 0; captured = 0; dropped = 0;
      while (captured < NUM_SAMPLES) begin
         d = 8'(base + step * off);
         adc_data = d;
         adc_valid = 1'b1;
         out_if.out_ready = 1'b1;
         afe = (off >= CAP_OFF) && (dropped < drop_n);
         if (off >= CAP_OFF) begin
            if (afe) dropped++;
            else begin
               captured++;
               exp_q.push_back(d);
               last_q.push_back(captured == NUM_SAMPLES);
            end
         end
         tick();
         off++;
      end
      adc_valid = 1'b0;
      afe = 1'b0;
      start_mc = mc_count; budget = 4000; k = 0;
      while (mc_count == start_mc && budget > 0) begin
         out_if.out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         if (ovr && k == 20) begin tip = 1'b1; ovr_cyc = cyc; end
         if (ovr && k == 23) tip = 1'b0;
         tick();
         budget--; k++;
      end
      if (budget == 0) begin
         vecs++; fails++;
         $display("FAIL line_timeout: got no mem_clear expected one (cycle %0d)", cyc);
      end
      tick(); tick();
      check("handshakes", hs_in_line, LINE_LEN);
      check("leftover", exp_q.size(), 0);
      model_line++;
   endtask

   int f1, f2, f3, f4, f5, saved_mc;

   initial begin
      out_if.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_if.out_valid, 0);
      check("rst_out_data", out_if.out_data, 0);
      check("rst_mem_clear", mem_clear, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b1;
      repeat (2) tick();

      // plain ramp, host always ready
      run_line(0, 0, 0, 0, 1, f1);
      check("t1_first_sample", line_fd[0], 8'd18);
      check("t1_last_sample", line_last[0], 8'd81);
      check("t1_first_valid_lat", first_valid_cyc - f1, 84);
`ifdef ECHO_HEADER_EN
      check("t1_mem_clear_lat", mc_cyc - f1, 215);
`else
      check("t1_mem_clear_lat", mc_cyc - f1, 211);
`endif

      // host ready one cycle in three
      run_line(0, 1, 0, 7, 3, f2);

      // first ten capture samples taken with the AFE still switched
      run_line(10, 0, 0, 0, 1, f3);
      check("t3_first_sample", line_fd[2], 8'd28);
      check("t3_last_sample", line_last[2], 8'd91);

`ifdef ECHO_HEADER_EN
      for (int i = 0; i < 3; i++) begin
         check("hdr_sync", line_b0[i], 8'hA5);
         check("hdr_line_idx", line_b1[i], i);
      end
`endif

      // transmit restarts while the line drains
      run_line(0, 0, 1, 100, 1, f4);
      check("t4_overrun_sticky", overrun, 1);

      // reset in the middle of capture, 20 samples in
      hs_in_line = 0;
      tip = 1'b1;
      repeat (3) tick();
      tip = 1'b0;
      for (int off = 0; off < CAP_OFF + 20; off++) begin
         adc_data = 8'(off);
         adc_valid = 1'b1;
         tick();
      end
      check("mid_busy", busy, 1);
      saved_mc = mc_count;
      #2 rst = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_out_valid", out_if.out_valid, 0);
      check("async_out_data", out_if.out_data, 0);
      check("async_mem_clear", mem_clear, 0);
      check("async_overrun", overrun, 0);
      exp_q.delete();
      last_q.delete();
      ovr_cyc = -1;
      model_line = 0;
      adc_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      check("no_clear_on_abort", mc_count, saved_mc);

      // clean line after the reset
      run_line(0, 0, 0, 50, 2, f5);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
